// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO read port into a registered valid/ready stream.
// A two-entry skid buffer keeps full throughput without an i_ready -> o_fifo_rden path.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_level,
  output logic [CNT_W-1:0]  o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              cnt_q, cnt_d;
  logic [DATA_W-1:0]   h0_q, h0_d;
  logic [DATA_W-1:0]   h1_q, h1_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_s;
  logic                take_s;

  // The pop request depends only on state, empty and flush so downstream ready never reaches the FIFO.
  assign o_fifo_rden = rstn & ~i_fifo_empty & ~i_flush & (cnt_q != ST_TWO);
  assign push_s      = o_fifo_rden;
  assign o_valid     = (cnt_q != ST_EMPTY);
  assign take_s      = o_valid & i_ready;
  assign o_data      = h0_q;
  assign o_level     = cnt_q;
  assign o_count     = count_q;

  // Next-state for the skid buffer and the delivered-word counter.
  always_comb begin
    cnt_d   = cnt_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    if (take_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    if (i_flush) begin
      cnt_d = ST_EMPTY;
    end else begin
      case (cnt_q)
        ST_EMPTY: begin
          if (push_s) begin
            cnt_d = ST_ONE;
            h0_d  = i_fifo_rddata;
          end else begin
            cnt_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && take_s) begin
            h0_d = i_fifo_rddata;
          end else if (push_s) begin
            cnt_d = ST_TWO;
            h1_d  = i_fifo_rddata;
          end else if (take_s) begin
            cnt_d = ST_EMPTY;
          end else begin
            cnt_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (take_s) begin
            cnt_d = ST_ONE;
            h0_d  = h1_q;
          end else begin
            cnt_d = ST_TWO;
          end
        end
        default: begin
          cnt_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= ST_EMPTY;
      h0_q    <= {DATA_W{1'b0}};
      h1_q    <= {DATA_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      count_q <= count_d;
    end
  end

endmodule
